// File: rtl/secure_reg_pkg.sv
// secure_reg_pkg
//   Shared types and constants for the sensitive-register write gate:
//   FSM state encoding, register-bus address map and the default
//   unlock key words.
package secure_reg_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      KEY1_WAIT = 2'd1,
      OPEN      = 2'd2,
      HLOCK     = 2'd3
   } state_e;

   // Address 3 is reserved and is rejected by the gate.
   typedef enum logic [1:0] {
      ADDR_DATA = 2'd0,
      ADDR_KEY  = 2'd1,
      ADDR_LOCK = 2'd2
   } addr_e;

   localparam logic [31:0] KEY0_DEF = 32'hA5A5_5A5A;
   localparam logic [31:0] KEY1_DEF = 32'h5A5A_A5A5;

endpackage

// File: rtl/secure_reg_window_timer.sv
// secure_reg_window_timer
//   Down-counter that bounds how long the gate stays unlocked.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     load_i    load the counter with WINDOW
//     dec_i     decrement by one (ignored at zero, load wins)
//     zero_o    counter reads zero
//     expire_o  counter reaches zero at the coming edge
module secure_reg_window_timer #(
   parameter int WINDOW = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o,
   output logic expire_o
);

   localparam int CW = $clog2(WINDOW + 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= CW'(WINDOW);
      end else if (dec_i && cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o   = (cnt_q == '0);
   assign expire_o = dec_i && (cnt_q == CW'(1));

endmodule

// File: rtl/secure_reg_write_gate.sv
// secure_reg_write_gate
//   Access-control front end for the sensitive data register. Checks
//   requester privilege, a two-word unlock sequence and a sticky hard lock;
//   only a qualified DATA write in OPEN produces a one-cycle wr_en pulse.
//   Every accepted request gets a registered OK/error response one cycle
//   after accept.
//   Optional build macro: SECURE_REG_AUDIT_EN adds the viol_cnt port, a
//   saturating count of errored responses.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     req_valid/req_ready          request handshake (ready = !rsp_valid)
//     req_addr/req_wdata/req_priv  request address, data, privilege
//     rsp_valid/rsp_err            response strobe and error flag
//     wr_en/wr_data                downstream register write
//     unlocked/hard_locked         state status (OPEN / HLOCK)
//     viol_cnt                     violation count (audit build only)
module secure_reg_write_gate
   import secure_reg_pkg::*;
#(
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] KEY0   = KEY0_DEF,
   parameter logic [DATA_W-1:0] KEY1   = KEY1_DEF,
   parameter int                WINDOW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              req_priv,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              unlocked,
   output logic              hard_locked
`ifdef SECURE_REG_AUDIT_EN
   ,output logic [7:0]       viol_cnt
`endif
);

   state_e state_q, state_d;
   logic   ready_q;
   logic   accept, err_d, wr_d;
   logic   tmr_load, tmr_dec, tmr_zero, tmr_expire;

   // ready_q keeps req_ready low through reset and rises one edge later.
   assign req_ready = ready_q && !rsp_valid;
   assign accept    = req_valid && req_ready;

   assign tmr_load = accept && req_priv && state_q == KEY1_WAIT &&
                     req_addr == ADDR_KEY && req_wdata == KEY1;
   // Accept cycles do not consume window time: accept beats expiry.
   assign tmr_dec  = (state_q == OPEN) && !accept && !tmr_zero;

   secure_reg_window_timer #(.WINDOW(WINDOW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (tmr_load),
      .dec_i    (tmr_dec),
      .zero_o   (tmr_zero),
      .expire_o (tmr_expire)
   );

   // Request decode; the rule order encodes precedence
   // (hard lock > reserved > privilege > LOCK > key/data sequence).
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      wr_d    = 1'b0;
      if (accept) begin
         err_d = 1'b1;
         if (state_q == HLOCK || req_addr == 2'd3) begin
            // error, no state change
         end else if (!req_priv) begin
            if (state_q == KEY1_WAIT) state_d = IDLE;
         end else if (req_addr == ADDR_LOCK) begin
            err_d = 1'b0;
            if (req_wdata[0]) state_d = HLOCK;
         end else begin
            case (state_q)
               IDLE: begin
                  if (req_addr == ADDR_KEY && req_wdata == KEY0) begin
                     state_d = KEY1_WAIT;
                     err_d   = 1'b0;
                  end
               end
               KEY1_WAIT: begin
                  state_d = IDLE;
                  if (req_addr == ADDR_KEY && req_wdata == KEY1) begin
                     state_d = OPEN;
                     err_d   = 1'b0;
                  end
               end
               OPEN: begin
                  state_d = IDLE;
                  if (req_addr == ADDR_DATA) begin
                     wr_d  = 1'b1;
                     err_d = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end else if (state_q == OPEN && (tmr_expire || tmr_zero)) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         wr_en     <= 1'b0;
         wr_data   <= '0;
      end else begin
         state_q   <= state_d;
         ready_q   <= 1'b1;
         rsp_valid <= accept;
         rsp_err   <= err_d;
         wr_en     <= wr_d;
         if (wr_d) wr_data <= req_wdata;
      end
   end

`ifdef SECURE_REG_AUDIT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         viol_cnt <= 8'd0;
      end else if (accept && err_d && viol_cnt != 8'hFF) begin
         viol_cnt <= viol_cnt + 8'd1;
      end
   end
`endif

   assign unlocked    = (state_q == OPEN);
   assign hard_locked = (state_q == HLOCK);

endmodule

// File: tb/tb_secure_reg_write_gate.sv
// tb_secure_reg_write_gate
//   Directed scenarios plus randomized traffic checked every cycle against
//   a rule-level reference model (unlock deadline kept as an absolute
//   cycle number).
module tb_secure_reg_write_gate;

   localparam int          WINDOW = 16;
   localparam logic [31:0] K0     = 32'hA5A5_5A5A;
   localparam logic [31:0] K1     = 32'h5A5A_A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_addr = 2'd0;
   logic [31:0] req_wdata = '0;
   logic        req_priv = 1'b0;
   logic        rsp_valid, rsp_err, wr_en, unlocked, hard_locked;
   logic [31:0] wr_data;
`ifdef SECURE_REG_AUDIT_EN
   logic [7:0]  viol_cnt;
`endif

   always #5 clk = ~clk;

   secure_reg_write_gate #(.DATA_W(32), .KEY0(K0), .KEY1(K1), .WINDOW(WINDOW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_priv    (req_priv),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .unlocked    (unlocked),
      .hard_locked (hard_locked)
`ifdef SECURE_REG_AUDIT_EN
      ,.viol_cnt   (viol_cnt)
`endif
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: 0 idle, 1 awaiting second key, 2 open, 3 hard locked
   int          m_st;
   int          cyc_n;
   int          m_deadline;
   bit          m_rv, m_err, m_wr;
   logic [31:0] m_wdata;
   int          m_viol;

   function automatic void model_reset();
      m_st = 0; m_rv = 0; m_err = 0; m_wr = 0; m_wdata = '0; m_viol = 0;
      m_deadline = 0;
   endfunction

   // Applies one clock edge to the model.
   function automatic void model_edge(bit acc, logic [1:0] a, logic [31:0] d, bit p);
      int prev = m_st;
      m_rv = acc; m_err = 0; m_wr = 0;
      if (acc) begin
         if (m_st == 3 || a == 2'd3) m_err = 1;
         else if (!p) begin
            m_err = 1;
            if (m_st == 1) m_st = 0;
         end else if (a == 2'd2) begin
            if (d[0]) m_st = 3;
         end else if (m_st == 0 && a == 2'd1 && d == K0) m_st = 1;
         else if (m_st == 1 && a == 2'd1 && d == K1) begin
            m_st = 2; m_deadline = cyc_n + WINDOW;
         end else if (m_st == 2 && a == 2'd0) begin
            m_wr = 1; m_wdata = d; m_st = 0;
         end else begin
            m_err = 1; m_st = 0;
         end
         // an accept that leaves the gate open does not use up window time
         if (prev == 2 && m_st == 2) m_deadline++;
         if (m_err && m_viol < 255) m_viol++;
      end else if (m_st == 2 && cyc_n >= m_deadline) begin
         m_st = 0;
      end
      cyc_n++;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".rsp_valid"}, rsp_valid, m_rv);
      chk({tag, ".rsp_err"}, rsp_err, m_err);
      chk({tag, ".wr_en"}, wr_en, m_wr);
      chk({tag, ".wr_data"}, wr_data, m_wdata);
      chk({tag, ".unlocked"}, unlocked, m_st == 2);
      chk({tag, ".hard_locked"}, hard_locked, m_st == 3);
`ifdef SECURE_REG_AUDIT_EN
      chk({tag, ".viol_cnt"}, viol_cnt, m_viol);
`endif
   endtask

   // One clock cycle, entered and left at a negedge.
   task automatic cyc(input string tag, input bit v, input logic [1:0] a,
                      input logic [31:0] d, input bit p);
      bit acc;
      req_valid = v; req_addr = a; req_wdata = d; req_priv = p;
      chk({tag, ".req_ready"}, req_ready, !m_rv);
      acc = v && !m_rv;
      model_edge(acc, a, d, p);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc("idle", 1'b0, 2'd0, '0, 1'b0);
   endtask

   // Waits out a pending response so the request is accepted.
   task automatic xfer(input string tag, input logic [1:0] a, input logic [31:0] d, input bit p);
      if (m_rv) idle(1);
      cyc(tag, 1'b1, a, d, p);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0;
      model_reset();
      #2;
      chk("rst.rsp_valid", rsp_valid, 1'b0);
      chk("rst.wr_en", wr_en, 1'b0);
      chk("rst.wr_data", wr_data, 32'h0);
      chk("rst.req_ready", req_ready, 1'b0);
      chk("rst.unlocked", unlocked, 1'b0);
      chk("rst.hard_locked", hard_locked, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst.ready_low_first", req_ready, 1'b0);
      @(negedge clk);
      chk("rst.ready_rise", req_ready, 1'b1);
   endtask

   initial begin
      int r, gap;
      bit p;
      model_reset();
      cyc_n = 0;
      #1;
      chk("por.rsp_valid", rsp_valid, 1'b0);
      do_reset();

      // good unlock and write
      xfer("good.k0", 2'd1, K0, 1);    chk("good.k0.err", rsp_err, 0);
      xfer("good.k1", 2'd1, K1, 1);    chk("good.k1.unl", unlocked, 1);
      xfer("good.data", 2'd0, 32'hDEADBEEF, 1);
      chk("good.wr_en", wr_en, 1);
      chk("good.wr_data", wr_data, 32'hDEADBEEF);
      chk("good.idle", unlocked, 0);
      idle(1);
      chk("good.wr_data_hold", wr_data, 32'hDEADBEEF);

      // bad key
      do_reset();
      xfer("bad.k0", 2'd1, K0, 1);              chk("bad.k0.err", rsp_err, 0);
      xfer("bad.k1", 2'd1, 32'h12345678, 1);    chk("bad.k1.err", rsp_err, 1);
      xfer("bad.data", 2'd0, 32'h1, 1);         chk("bad.data.err", rsp_err, 1);
      chk("bad.no_wr", wr_en, 0);
`ifdef SECURE_REG_AUDIT_EN
      chk("bad.viol", viol_cnt, 8'd2);
`endif

      // unprivileged
      xfer("unp.k0", 2'd1, K0, 0);              chk("unp.k0.err", rsp_err, 1);
      xfer("unp.k1", 2'd1, K1, 0);              chk("unp.k1.err", rsp_err, 1);
      xfer("unp.data", 2'd0, 32'h55, 0);        chk("unp.data.err", rsp_err, 1);
      chk("unp.unl", unlocked, 0);

      // window expiry and boundary
      xfer("win.k0", 2'd1, K0, 1);
      xfer("win.k1", 2'd1, K1, 1);
      idle(WINDOW);
      chk("win.expired", unlocked, 0);
      xfer("win.late", 2'd0, 32'h11, 1);       chk("win.late.err", rsp_err, 1);
      chk("win.late.no_wr", wr_en, 0);
      xfer("win.k0b", 2'd1, K0, 1);
      xfer("win.k1b", 2'd1, K1, 1);
      idle(WINDOW - 1);
      chk("win.last_open", unlocked, 1);
      cyc("win.edge", 1'b1, 2'd0, 32'h22, 1);  chk("win.edge.err", rsp_err, 0);
      chk("win.edge.wr", wr_en, 1);

      // hard lock
      xfer("hl.lock", 2'd2, 32'h1, 1);         chk("hl.lock.err", rsp_err, 0);
      xfer("hl.k0", 2'd1, K0, 1);              chk("hl.k0.err", rsp_err, 1);
      xfer("hl.k1", 2'd1, K1, 1);              chk("hl.k1.err", rsp_err, 1);
      xfer("hl.data", 2'd0, 32'h33, 1);        chk("hl.data.err", rsp_err, 1);
      chk("hl.persist", hard_locked, 1);
      do_reset();
      xfer("hl.k0r", 2'd1, K0, 1);
      xfer("hl.k1r", 2'd1, K1, 1);
      xfer("hl.datar", 2'd0, 32'h44, 1);       chk("hl.datar.wr", wr_en, 1);

      // reset the cycle after a DATA accept in OPEN
      idle(1);
      xfer("mid.k0", 2'd1, K0, 1);
      xfer("mid.k1", 2'd1, K1, 1);
      idle(1);
      req_valid = 1; req_addr = 2'd0; req_wdata = 32'h99; req_priv = 1;
      @(posedge clk);
      #1 rst = 1'b1; req_valid = 1'b0;
      #2;
      chk("mid.rsp_valid", rsp_valid, 0);
      chk("mid.wr_en", wr_en, 0);
      chk("mid.wr_data", wr_data, 32'h0);
      chk("mid.unlocked", unlocked, 0);
      do_reset();

      // randomized traffic
      for (int it = 0; it < 1200; it++) begin
         if (it % 150 == 149) do_reset();
         gap = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
         idle(gap);
         r = $urandom_range(0, 99);
         p = ($urandom_range(0, 9) != 0);
         if (r < 30)      xfer("rnd", 2'd1, K0, p);
         else if (r < 55) xfer("rnd", 2'd1, K1, p);
         else if (r < 75) xfer("rnd", 2'd0, $urandom, p);
         else if (r < 80) xfer("rnd", 2'd2, ($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0, p);
         else             xfer("rnd", 2'($urandom_range(0, 3)), $urandom, p);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/secure_reg_write_gate.md
# secure_reg_write_gate

Access-control front end for the sensitive data register block. It accepts register-bus write requests and checks requester privilege, a two-word unlock key sequence and a sticky hard lock. Only qualified data writes reach the downstream register, as a single-cycle `wr_en`/`wr_data` pulse. Every request receives an OK or error response.

## Interface
Parameters:
- `DATA_W`, 32, data/key width.
- `KEY0`, 32'hA5A5_5A5A, first unlock word.
- `KEY1`, 32'h5A5A_A5A5, second unlock word.
- `WINDOW`, 16, cycles the unlock window stays open (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  write request present.
- `req_ready`  out  1  gate can accept a request.
- `req_addr`  in  2  0=DATA, 1=KEY, 2=LOCK, 3=reserved.
- `req_wdata`  in  DATA_W  request write data.
- `req_priv`  in  1  1 = privileged requester.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_err`  out  1  error flag, valid with `rsp_valid`.
- `wr_en`  out  1  write strobe to the sensitive register.
- `wr_data`  out  DATA_W  data for the sensitive register.
- `unlocked`  out  1  high while in OPEN.
- `hard_locked`  out  1  high while in HLOCK.
- `viol_cnt`  out  8  violation count (only with `SECURE_REG_AUDIT_EN`).

## Operation
- **Reset:**
  - State goes to IDLE.
  - All outputs reset to 0, including `wr_data`, window counter and `viol_cnt`.
  - `req_ready` rises on the first cycle after reset release.
- **Accept rule:** a request is accepted when `req_valid && req_ready`.
- **Non-privileged requests:** any accepted request with `req_priv`=0 errors.
  - From KEY1_WAIT the state returns to IDLE.
  - From any other state the state is unchanged.
- **IDLE:**
  - KEY write with `KEY0` goes to KEY1_WAIT, OK.
  - Any other KEY value, or a DATA write, errors; state stays IDLE.
- **KEY1_WAIT:**
  - KEY write with `KEY1` goes to OPEN, OK, and loads the window counter with `WINDOW`.
  - Any other request errors and returns to IDLE.
- **OPEN:**
  - DATA write: `wr_en`=1 and `wr_data`=`req_wdata`, OK, return to IDLE. Each unlock grants exactly one write.
  - KEY write: errors, return to IDLE.
  - The window counter decrements every cycle with no accept. At 0 the state returns to IDLE with no response.
- **LOCK write:**
  - Privileged, `req_wdata[0]`=1, from any non-HLOCK state: goes to HLOCK, OK.
  - `req_wdata[0]`=0: OK, no state change.
- **HLOCK:** every request errors. Only `rst` leaves this state.
- **Reserved address:** always errors, no state change.
- **`wr_data`:** holds its last value between writes.

## Timing
- **Response:** registered. `rsp_valid`, `rsp_err` and `wr_en` assert on the cycle after accept, together.
- **Throughput:**
  - `req_ready` = !`rsp_valid`, so at most one request every 2 cycles.
  - Downstream write latency is 1 cycle from accept.
- **Window boundary:**
  - A DATA accept on the cycle the counter reads 1 is honoured.
  - The counter reaches 0 at the following edge, and OPEN→IDLE happens on that edge.
  - Accept has priority over expiry on the same edge.
- **Reset mid-operation:**
  - Asynchronously clears state, counter and all strobes.
  - A pending response is dropped and no `wr_en` is issued.
- **Status outputs:** `unlocked` and `hard_locked` are decoded from registered state, with no combinational path from request inputs.

## Configuration
- **`SECURE_REG_AUDIT_EN` defined:**
  - `viol_cnt` increments, saturating at 255, on every errored response.
  - It resets to 0 on `rst`.
- **Undefined:** the `viol_cnt` port and its counter are absent. All other behaviour is identical.

## Structure
- **Shared package `secure_reg_pkg`:**
  - State enum {IDLE, KEY1_WAIT, OPEN, HLOCK}.
  - Address enum {ADDR_DATA, ADDR_KEY, ADDR_LOCK}.
  - Default `KEY0`/`KEY1` constants.
- **Sub-module `secure_reg_window_timer`:** load/decrement/zero-flag down-counter sized `$clog2(WINDOW+1)`.
- **Top module:** FSM, response register and write strobe.

## Test plan
- **Good unlock and write:** privileged KEY `A5A55A5A`, KEY `5A5AA5A5`, DATA `DEADBEEF`. Three OK responses; single `wr_en` with `wr_data`=`DEADBEEF`; then IDLE.
- **Bad key:** KEY `A5A55A5A`, KEY `12345678`, DATA `1`. Responses err=0, err=1, err=1; no `wr_en`; `viol_cnt`=2 with the macro.
- **Unprivileged access:** unlock sequence sent with `req_priv`=0. All three responses error; no `wr_en`; `unlocked` stays 0.
- **Window expiry:** unlock, idle 16 cycles, then DATA write. Error and no `wr_en`. Also: DATA accepted on the counter=1 cycle gives OK and `wr_en`.
- **Hard lock:** LOCK `1`, then a full unlock sequence and a DATA write. LOCK is OK, everything after errors, `hard_locked`=1 persists. Assert `rst`: `hard_locked`=0 and normal unlock works.
- **Reset mid-operation:** `rst` asserted the cycle after the DATA accept in OPEN. No `rsp_valid`/`wr_en`; all outputs 0; state IDLE.
